cache_fill_fsm: RTL and testbench
=================================

Name: cache_fill_fsm

Overview:
- Miss-handling controller between the L1 cache arrays and the 16-bit, byte-addressed, word-wide main memory.
- On a cache miss it fetches the full 16-byte block (8 words) from memory, one request per cycle, with pipelined returns.
- It steers each returned word into the cache data array, then writes the tag.
- Memory returns data a fixed but unknown number of cycles after each request; the FSM tracks returns only through mem_data_valid.

Parameters:
- ADDR_WIDTH, 16, byte-address width.
- WORDS_PER_BLOCK, 8, words per cache block; must be a power of 2.
- OFFSET_BITS, 4, byte-offset bits of a block; equals log2(2*WORDS_PER_BLOCK).

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- miss_detected  input  1  cache miss this cycle; sampled only in IDLE.
- miss_address  input  ADDR_WIDTH  byte address of the missing access.
- fsm_busy  output  1  high while a fill is in progress; the pipeline stalls on it.
- mem_enable  output  1  memory read request strobe.
- mem_address  output  ADDR_WIDTH  word-aligned request address.
- mem_data_valid  input  1  returned word valid this cycle.
- write_data_array  output  1  write mem_data into the data array at word_sel this cycle.
- word_sel  output  log2(WORDS_PER_BLOCK)  word offset of the returned word.
- write_tag_array  output  1  write the tag/valid for the block base this cycle.
- fill_done  output  1  one-cycle pulse after the last word is written.

Behaviour:
- States: IDLE and FILL. Reset forces IDLE.
- Counters and reset values: req_cnt and rcv_cnt are (log2 WPB)+1 bits, reset to 0. All outputs reset to 0.
- IDLE, miss_detected=1:
  - Latch base = miss_address with the low OFFSET_BITS bits cleared.
  - Clear both counters; go to FILL next cycle. fsm_busy rises on that next edge.
- FILL, requests:
  - While req_cnt < WPB: mem_enable=1, mem_address = base + 2*req_cnt; req_cnt increments each cycle.
  - After the last request: mem_enable=0 and mem_address=0.
- FILL, returns:
  - Each cycle with mem_data_valid=1: write_data_array=1 (combinational from valid), word_sel=rcv_cnt, then rcv_cnt increments.
  - Gaps in valid (memory stall) are allowed and add no writes.
- Completion:
  - On the valid that carries rcv_cnt = WPB-1, write_tag_array=1 in the same cycle.
  - Next cycle: state IDLE, fsm_busy=0, fill_done=1 for one cycle.
  - Minimum fill time with 1-cycle memory latency: 9 cycles of busy.
- Ignored inputs:
  - miss_detected during FILL is ignored; the cache re-presents the miss after the stall.
  - mem_data_valid in IDLE is ignored: no array writes.
  - miss_address bit 0 is ignored.
- Wrap-around: address arithmetic is modulo 2^ADDR_WIDTH within the block only. Base 0xFFF0 issues 0xFFF0 through 0xFFFE and never carries.
- Reset mid-FILL: IDLE next cycle, counters cleared, no tag write. Late valids after reset are ignored.
- Back-to-back misses: miss_detected in the same cycle fill_done=1 (state IDLE) starts a new fill.

Optional Feature:
- Macro: CRITICAL_WORD_FIRST_EN.
- Defined:
  - The request offset starts at the missing word, miss_address[OFFSET_BITS-1:1], and wraps modulo WPB.
  - word_sel follows the same order: (start + rcv_cnt) mod WPB.
  - Example: miss at 0x100A issues 0x100A, 0x100C, 0x100E, 0x1000, ..., 0x1008.
- Undefined: requests always start at offset 0; the miss word offset is unused.

Decomposition:
- Shared package cache_pkg holds:
  - the state enum, fill_state_t {IDLE, FILL};
  - constants WORDS_PER_BLOCK, OFFSET_BITS and WORD_IDX_W.
- One natural sub-module, fill_counter: a reusable modulo/saturating counter with enable and clear. It is instantiated twice, for request and receive counts.

Test Plan:
- Basic fill:
  - Stimulus: rst, then miss at 0x1234, with a memory model of latency 4.
  - Required: requests 0x1230 through 0x123E on 8 consecutive cycles; 8 write_data_array pulses with word_sel 0..7; write_tag_array with word 7; fill_done once; busy for 12 cycles.
- Stalled memory: valid is deasserted for 3 cycles after word 2 → word_sel stays 3 until the next valid; total writes = 8; busy is extended by 3.
- Miss while busy: miss_detected pulses at 0x2000 during a fill of 0x1000 → no change to the latched base; only 0x1000-block addresses are issued.
- Reset mid-fill:
  - Stimulus: rst asserted after word 4, then one stray valid.
  - Required: no tag write, outputs 0 the cycle after rst, stray valid ignored.
  - Then a miss at 0x0040 fills cleanly.
- Wrap: miss at 0xFFFF → base 0xFFF0, last request 0xFFFE, no request at 0x0000.
- CRITICAL_WORD_FIRST_EN: miss at 0x100A → first request 0x100A with word_sel 5, order 5,6,7,0,1,2,3,4; tag written with the 8th word.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared definitions for the cache miss fill controller: block geometry,
// fill state encoding and the request-address helper.
package cache_pkg;

    localparam int ADDR_WIDTH      = 16;
    localparam int WORDS_PER_BLOCK = 8;
    localparam int OFFSET_BITS     = 4;
    localparam int WORD_IDX_W      = $clog2(WORDS_PER_BLOCK);
    localparam int CNT_W           = WORD_IDX_W + 1;
    localparam int BLK_W           = ADDR_WIDTH - OFFSET_BITS;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_t;

    // Word-aligned byte address of word 'off' inside block 'blk'. The block
    // bits are passed through untouched, so offsets never carry out of the block.
    function automatic logic [ADDR_WIDTH-1:0] block_addr(
        input logic [BLK_W-1:0]      blk,
        input logic [WORD_IDX_W-1:0] off
    );
        return {blk, off, 1'b0};
    endfunction

endpackage

// File: rtl/cache_fill_fsm_counter.sv
// Small up-counter with synchronous clear and enable. With SATURATE set it
// holds at all-ones instead of wrapping.
module fill_counter #(
    parameter int WIDTH    = 4,
    parameter bit SATURATE = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;

    // Count enabled cycles; reset and clear both return to zero.
    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            count_q <= '0;
        end else if (en_i && !(SATURATE && (&count_q))) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss fill controller: fetches a whole block from main memory, one
// request per cycle, and steers the returned words into the data array,
// writing the tag together with the last word.
// Optional build macro CRITICAL_WORD_FIRST_EN: start the request sequence at
// the missing word and wrap around the block.
//
// state | meaning
// IDLE  | waiting for a miss; returns from memory are ignored
// FILL  | issuing block requests and collecting returned words
module cache_fill_fsm
    import cache_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  miss_detected,
    input  logic [ADDR_WIDTH-1:0] miss_address,
    output logic                  fsm_busy,
    output logic                  mem_enable,
    output logic [ADDR_WIDTH-1:0] mem_address,
    input  logic                  mem_data_valid,
    output logic                  write_data_array,
    output logic [WORD_IDX_W-1:0] word_sel,
    output logic                  write_tag_array,
    output logic                  fill_done
);

    fill_state_t           state_q;
    logic [BLK_W-1:0]      base_q;
    logic                  busy_q;
    logic                  mem_en_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic                  done_q;

    logic [CNT_W-1:0]      req_cnt;
    logic [CNT_W-1:0]      rcv_cnt;
    logic                  cnt_clr;
    logic                  rx_fire;
    logic                  last_rx;
    logic                  last_req;
    logic [WORD_IDX_W-1:0] start_off;
    logic [WORD_IDX_W-1:0] miss_start;
    logic [WORD_IDX_W-1:0] next_req_off;

`ifdef CRITICAL_WORD_FIRST_EN
    logic [WORD_IDX_W-1:0] start_q;
    logic                  unused_byte_bit;

    assign miss_start      = miss_address[OFFSET_BITS-1:1];
    assign unused_byte_bit = miss_address[0];

    // Remember which word missed; it fixes both request and write order.
    always_ff @(posedge clk) begin
        if (rst) begin
            start_q <= '0;
        end else if (state_q == IDLE && miss_detected) begin
            start_q <= miss_start;
        end
    end

    assign start_off = start_q;
`else
    logic unused_offset_bits;

    assign miss_start         = '0;
    assign start_off          = '0;
    assign unused_offset_bits = ^miss_address[OFFSET_BITS-1:0];
`endif

    // Counters stay cleared while idle, so every fill starts from zero.
    assign cnt_clr      = (state_q == IDLE);
    assign rx_fire      = (state_q == FILL) && mem_data_valid;
    assign last_rx      = rx_fire && (rcv_cnt == CNT_W'(WORDS_PER_BLOCK - 1));
    assign last_req     = (req_cnt == CNT_W'(WORDS_PER_BLOCK - 1));
    assign next_req_off = start_off + req_cnt[WORD_IDX_W-1:0] + WORD_IDX_W'(1);

    fill_counter #(
        .WIDTH    (CNT_W),
        .SATURATE (1'b1)
    ) u_req_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (cnt_clr),
        .en_i    (mem_en_q),
        .count_o (req_cnt)
    );

    fill_counter #(
        .WIDTH    (CNT_W),
        .SATURATE (1'b1)
    ) u_rcv_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (cnt_clr),
        .en_i    (rx_fire),
        .count_o (rcv_cnt)
    );

    // Fill sequencing with registered busy, request and done outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            base_q     <= '0;
            busy_q     <= 1'b0;
            mem_en_q   <= 1'b0;
            mem_addr_q <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (miss_detected) begin
                        state_q    <= FILL;
                        busy_q     <= 1'b1;
                        base_q     <= miss_address[ADDR_WIDTH-1:OFFSET_BITS];
                        mem_en_q   <= 1'b1;
                        mem_addr_q <= block_addr(miss_address[ADDR_WIDTH-1:OFFSET_BITS],
                                                 miss_start);
                    end
                end
                FILL: begin
                    if (mem_en_q) begin
                        if (last_req) begin
                            mem_en_q   <= 1'b0;
                            mem_addr_q <= '0;
                        end else begin
                            mem_addr_q <= block_addr(base_q, next_req_off);
                        end
                    end
                    if (last_rx) begin
                        state_q    <= IDLE;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        mem_en_q   <= 1'b0;
                        mem_addr_q <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign fsm_busy         = busy_q;
    assign mem_enable       = mem_en_q;
    assign mem_address      = mem_addr_q;
    assign fill_done        = done_q;
    assign write_data_array = rx_fire;
    assign write_tag_array  = last_rx;
    assign word_sel         = start_off + rcv_cnt[WORD_IDX_W-1:0];

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Self-checking bench for cache_fill_fsm with a latency-programmable memory
// model and a block-order reference model.
module tb_cache_fill_fsm;

`ifdef CRITICAL_WORD_FIRST_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        miss_detected = 1'b0;
    logic [15:0] miss_address = 16'h0;
    logic        mem_data_valid = 1'b0;
    logic        fsm_busy, mem_enable, write_data_array, write_tag_array, fill_done;
    logic [15:0] mem_address;
    logic [2:0]  word_sel;

    int total = 0;
    int bad = 0;

    cache_fill_fsm dut (
        .clk              (clk),
        .rst              (rst),
        .miss_detected    (miss_detected),
        .miss_address     (miss_address),
        .fsm_busy         (fsm_busy),
        .mem_enable       (mem_enable),
        .mem_address      (mem_address),
        .mem_data_valid   (mem_data_valid),
        .write_data_array (write_data_array),
        .word_sel         (word_sel),
        .write_tag_array  (write_tag_array),
        .fill_done        (fill_done)
    );

    always #5 clk = ~clk;

    // Reference: block base plus 2 bytes per word, starting at the critical
    // word when that ordering is enabled, wrapping inside the 8-word block.
    function automatic int exp_sel(input logic [15:0] a, input int i);
        int s;
        s = CWF ? int'(a[3:1]) : 0;
        return (s + i) % 8;
    endfunction

    function automatic logic [15:0] exp_req(input logic [15:0] a, input int i);
        return 16'(int'(a & 16'hFFF0) + 2 * exp_sel(a, i));
    endfunction

    // Observations from the most recent fill.
    logic [15:0] req_q[$];
    int          req_c[$];
    logic [2:0]  sel_q[$];
    int          wr_c[$];
    int          tag_c[$];
    int          tag_nwr[$];
    logic [2:0]  idle_sel[$];
    int          done_n, done_c, busy_n, busy_first, addr_nz;
    logic        busy0;
    bit          tmo;

    // Drive one fill (miss in cycle 0) and record what the DUT does, with a
    // memory returning each request 'lat' cycles later. Returns at the
    // negedge of the fill_done cycle, with miss/valid dropped.
    task automatic do_fill(input logic [15:0] a, input int lat, input int stall_after,
                           input int stall_len, input bit rnd, input bit intr,
                           input bit skip_wait);
        int ret_q[$];
        int stall_left;
        bit fin, v;
        req_q.delete(); req_c.delete(); sel_q.delete(); wr_c.delete();
        tag_c.delete(); tag_nwr.delete(); idle_sel.delete();
        done_n = 0; done_c = -1; busy_n = 0; busy_first = -1; addr_nz = 0;
        busy0 = 1'b0; stall_left = 0; fin = 1'b0;
        for (int c = 0; c < 150 && !fin; c++) begin
            if (!(c == 0 && skip_wait)) @(negedge clk);
            if (c > 0 && fill_done) begin
                done_n++; done_c = c; fin = 1'b1;
                mem_data_valid = 1'b0; miss_detected = 1'b0;
            end else begin
                miss_detected = (c == 0) || (intr && c == 3);
                miss_address  = (c == 0) ? a : ((intr && c == 3) ? 16'h2000 : 16'($urandom));
                v = 1'b0;
                if (stall_left > 0) stall_left--;
                else if (ret_q.size() > 0 && ret_q[0] <= c && (!rnd || $urandom_range(0, 2) != 0)) begin
                    v = 1'b1;
                    void'(ret_q.pop_front());
                end
                mem_data_valid = v;
                #1;
                if (c == 0) busy0 = fsm_busy;
                if (fsm_busy) begin
                    busy_n++;
                    if (busy_first < 0) busy_first = c;
                    if (!mem_enable && mem_address != 16'h0) addr_nz++;
                end
                if (mem_enable) begin
                    req_q.push_back(mem_address); req_c.push_back(c); ret_q.push_back(c + lat);
                end
                if (write_data_array) begin
                    sel_q.push_back(word_sel); wr_c.push_back(c);
                    if (stall_after == sel_q.size() - 1) stall_left = stall_len;
                end else if (fsm_busy) begin
                    idle_sel.push_back(word_sel);
                end
                if (write_tag_array) begin
                    tag_c.push_back(c); tag_nwr.push_back(sel_q.size());
                end
            end
        end
        tmo = !fin;
        if (!fin) begin
            mem_data_valid = 1'b0; miss_detected = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        mem_data_valid = 1'b1;
        #1;
        total++; if (fsm_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", fsm_busy); end
        total++; if (mem_enable !== 1'b0) begin bad++; $display("FAIL reset_mem_enable: got %b want 0", mem_enable); end
        total++; if (mem_address !== 16'h0) begin bad++; $display("FAIL reset_mem_address: got %h want 0000", mem_address); end
        total++; if (write_data_array !== 1'b0) begin bad++; $display("FAIL idle_valid_write: got %b want 0", write_data_array); end
        total++; if (write_tag_array !== 1'b0) begin bad++; $display("FAIL idle_valid_tag: got %b want 0", write_tag_array); end
        total++; if (fill_done !== 1'b0) begin bad++; $display("FAIL reset_fill_done: got %b want 0", fill_done); end
        total++; if (word_sel !== 3'd0) begin bad++; $display("FAIL reset_word_sel: got %0d want 0", word_sel); end
        @(negedge clk);
        mem_data_valid = 1'b0;
    endtask

    task automatic test_basic();
        logic [15:0] a;
        a = 16'h1234;
        do_fill(a, 4, -1, 0, 1'b0, 1'b0, 1'b0);
        total++; if (tmo) begin bad++; $display("FAIL basic_timeout: got timeout want fill_done"); end
        total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL basic_busy_early: got %b want 0", busy0); end
        total++; if (req_q.size() != 8) begin bad++; $display("FAIL basic_req_count: got %0d want 8", req_q.size()); end
        for (int i = 0; i < req_q.size(); i++) begin
            total++; if (req_q[i] !== exp_req(a, i) || req_c[i] != i + 1) begin
                bad++; $display("FAIL basic_req[%0d]: got %h@%0d want %h@%0d", i, req_q[i], req_c[i], exp_req(a, i), i + 1);
            end
        end
        total++; if (sel_q.size() != 8) begin bad++; $display("FAIL basic_write_count: got %0d want 8", sel_q.size()); end
        for (int i = 0; i < sel_q.size(); i++) begin
            total++; if (sel_q[i] !== 3'(exp_sel(a, i)) || wr_c[i] != i + 5) begin
                bad++; $display("FAIL basic_sel[%0d]: got %0d@%0d want %0d@%0d", i, sel_q[i], wr_c[i], exp_sel(a, i), i + 5);
            end
        end
        total++; if (tag_c.size() != 1 || tag_nwr[0] != 8 || tag_c[0] != 12) begin
            bad++; $display("FAIL basic_tag: got %0d tag writes, first at %0d want 1 at 12 with word 8", tag_c.size(), (tag_c.size() > 0) ? tag_c[0] : -1);
        end
        total++; if (done_n != 1 || done_c != 13) begin bad++; $display("FAIL basic_done: got %0d@%0d want 1@13", done_n, done_c); end
        total++; if (busy_n != 12 || busy_first != 1) begin bad++; $display("FAIL basic_busy: got %0d from %0d want 12 from 1", busy_n, busy_first); end
        total++; if (addr_nz != 0) begin bad++; $display("FAIL basic_idle_addr: got %0d nonzero want 0", addr_nz); end
        @(negedge clk); #1;
        total++; if (fill_done !== 1'b0 || fsm_busy !== 1'b0) begin
            bad++; $display("FAIL basic_done_pulse: got done=%b busy=%b want 0 0", fill_done, fsm_busy);
        end
    endtask

    task automatic test_stall();
        logic [15:0] a;
        a = 16'($urandom);
        do_fill(a, 4, 2, 3, 1'b0, 1'b0, 1'b0);
        total++; if (tmo || sel_q.size() != 8) begin bad++; $display("FAIL stall_writes: got %0d (timeout %0d) want 8", sel_q.size(), tmo); end
        for (int i = 0; i < sel_q.size(); i++) begin
            total++; if (sel_q[i] !== 3'(exp_sel(a, i))) begin bad++; $display("FAIL stall_sel[%0d]: got %0d want %0d", i, sel_q[i], exp_sel(a, i)); end
        end
        total++; if (busy_n != 15) begin bad++; $display("FAIL stall_busy: got %0d want 15", busy_n); end
        total++; if (idle_sel.size() != 7) begin bad++; $display("FAIL stall_gap_cycles: got %0d want 7", idle_sel.size()); end
        for (int i = 4; i < idle_sel.size(); i++) begin
            total++; if (idle_sel[i] !== 3'(exp_sel(a, 3))) begin bad++; $display("FAIL stall_hold_sel[%0d]: got %0d want %0d", i, idle_sel[i], exp_sel(a, 3)); end
        end
        total++; if (tag_c.size() != 1 || tag_nwr[0] != 8) begin bad++; $display("FAIL stall_tag: got %0d tag writes want 1", tag_c.size()); end
    endtask

    task automatic test_miss_while_busy();
        logic [15:0] a;
        a = 16'h1000;
        do_fill(a, 3, -1, 0, 1'b0, 1'b1, 1'b0);
        total++; if (tmo || req_q.size() != 8) begin bad++; $display("FAIL busy_miss_req_count: got %0d want 8", req_q.size()); end
        for (int i = 0; i < req_q.size(); i++) begin
            total++; if ((req_q[i] & 16'hFFF0) !== 16'h1000 || req_q[i] !== exp_req(a, i)) begin
                bad++; $display("FAIL busy_miss_req[%0d]: got %h want %h", i, req_q[i], exp_req(a, i));
            end
        end
        @(negedge clk); #1;
        total++; if (fsm_busy !== 1'b0 || mem_enable !== 1'b0) begin
            bad++; $display("FAIL busy_miss_restart: got busy=%b en=%b want 0 0", fsm_busy, mem_enable);
        end
    endtask

    task automatic test_reset_mid_fill();
        int rq[$];
        int w, tags;
        bit v;
        w = 0; tags = 0;
        @(negedge clk);
        miss_detected = 1'b1; miss_address = 16'h5678; mem_data_valid = 1'b0;
        for (int c = 1; c < 60 && w < 5; c++) begin
            @(negedge clk);
            miss_detected = 1'b0;
            v = (rq.size() > 0 && rq[0] <= c);
            if (v) void'(rq.pop_front());
            mem_data_valid = v;
            #1;
            if (mem_enable) rq.push_back(c + 2);
            if (write_data_array) w++;
            if (write_tag_array) tags++;
        end
        total++; if (w != 5) begin bad++; $display("FAIL rst_mid_progress: got %0d writes want 5", w); end
        @(negedge clk);
        rst = 1'b1; mem_data_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0; mem_data_valid = 1'b1;
        #1;
        total++; if (fsm_busy !== 1'b0 || mem_enable !== 1'b0 || mem_address !== 16'h0 || fill_done !== 1'b0) begin
            bad++; $display("FAIL rst_mid_outputs: got busy=%b en=%b addr=%h done=%b want 0 0 0000 0", fsm_busy, mem_enable, mem_address, fill_done);
        end
        total++; if (write_data_array !== 1'b0 || write_tag_array !== 1'b0 || word_sel !== 3'd0) begin
            bad++; $display("FAIL rst_mid_stray: got wr=%b tag=%b sel=%0d want 0 0 0", write_data_array, write_tag_array, word_sel);
        end
        total++; if (tags != 0) begin bad++; $display("FAIL rst_mid_tag: got %0d want 0", tags); end
        @(negedge clk);
        mem_data_valid = 1'b0;
        do_fill(16'h0040, 3, -1, 0, 1'b0, 1'b0, 1'b0);
        total++; if (tmo || req_q.size() != 8 || sel_q.size() != 8 || tag_c.size() != 1 || done_n != 1) begin
            bad++; $display("FAIL rst_refill: got req=%0d wr=%0d tag=%0d done=%0d want 8 8 1 1", req_q.size(), sel_q.size(), tag_c.size(), done_n);
        end
        for (int i = 0; i < req_q.size(); i++) begin
            total++; if (req_q[i] !== exp_req(16'h0040, i)) begin bad++; $display("FAIL rst_refill_req[%0d]: got %h want %h", i, req_q[i], exp_req(16'h0040, i)); end
        end
    endtask

    task automatic test_wrap();
        logic [15:0] a;
        a = 16'hFFFF;
        do_fill(a, 1, -1, 0, 1'b0, 1'b0, 1'b0);
        total++; if (tmo || req_q.size() != 8) begin bad++; $display("FAIL wrap_req_count: got %0d want 8", req_q.size()); end
        for (int i = 0; i < req_q.size(); i++) begin
            total++; if (req_q[i] < 16'hFFF0 || req_q[i] !== exp_req(a, i)) begin
                bad++; $display("FAIL wrap_req[%0d]: got %h want %h", i, req_q[i], exp_req(a, i));
            end
        end
`ifndef CRITICAL_WORD_FIRST_EN
        total++; if (req_q.size() != 8 || req_q[7] !== 16'hFFFE) begin bad++; $display("FAIL wrap_last: got %h want fffe", (req_q.size() == 8) ? req_q[7] : 16'h0); end
`endif
        total++; if (busy_n != 9) begin bad++; $display("FAIL wrap_min_busy: got %0d want 9", busy_n); end
    endtask

    task automatic test_order();
        logic [2:0]  order [8];
        logic [15:0] first;
`ifdef CRITICAL_WORD_FIRST_EN
        order = '{3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
        first = 16'h100A;
`else
        order = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        first = 16'h1000;
`endif
        do_fill(16'h100A, 2, -1, 0, 1'b0, 1'b0, 1'b0);
        total++; if (tmo || req_q.size() != 8 || req_q[0] !== first) begin
            bad++; $display("FAIL order_first_req: got %h want %h", (req_q.size() > 0) ? req_q[0] : 16'h0, first);
        end
        total++; if (sel_q.size() != 8) begin bad++; $display("FAIL order_write_count: got %0d want 8", sel_q.size()); end
        for (int i = 0; i < sel_q.size(); i++) begin
            total++; if (sel_q[i] !== order[i]) begin bad++; $display("FAIL order_sel[%0d]: got %0d want %0d", i, sel_q[i], order[i]); end
        end
        total++; if (tag_c.size() != 1 || tag_nwr[0] != 8 || wr_c.size() != 8 || tag_c[0] != wr_c[7]) begin
            bad++; $display("FAIL order_tag: got %0d tag writes want 1 with 8th word", tag_c.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] b;
        b = 16'($urandom);
        do_fill(16'h2468, 3, -1, 0, 1'b0, 1'b0, 1'b0);
        total++; if (tmo || done_n != 1) begin bad++; $display("FAIL b2b_first_done: got %0d want 1", done_n); end
        do_fill(b, 2, -1, 0, 1'b0, 1'b0, 1'b1);
        total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL b2b_busy_gap: got %b want 0", busy0); end
        total++; if (tmo || req_q.size() != 8 || req_c[0] != 1) begin
            bad++; $display("FAIL b2b_start: got %0d reqs first at %0d want 8 at 1", req_q.size(), (req_c.size() > 0) ? req_c[0] : -1);
        end
        for (int i = 0; i < req_q.size(); i++) begin
            total++; if (req_q[i] !== exp_req(b, i)) begin bad++; $display("FAIL b2b_req[%0d]: got %h want %h", i, req_q[i], exp_req(b, i)); end
        end
        total++; if (busy_n != 10 || done_n != 1) begin bad++; $display("FAIL b2b_busy: got %0d done %0d want 10 1", busy_n, done_n); end
    endtask

    task automatic test_random();
        logic [15:0] a;
        int lat;
        for (int n = 0; n < 8; n++) begin
            a   = 16'($urandom);
            lat = $urandom_range(1, 6);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_fill(a, lat, -1, 0, 1'b1, 1'b0, 1'b0);
            total++; if (tmo || req_q.size() != 8 || sel_q.size() != 8) begin
                bad++; $display("FAIL rnd%0d_counts: got req=%0d wr=%0d want 8 8", n, req_q.size(), sel_q.size());
            end
            for (int i = 0; i < req_q.size(); i++) begin
                total++; if (req_q[i] !== exp_req(a, i) || req_c[i] != i + 1) begin
                    bad++; $display("FAIL rnd%0d_req[%0d]: got %h@%0d want %h@%0d", n, i, req_q[i], req_c[i], exp_req(a, i), i + 1);
                end
            end
            for (int i = 0; i < sel_q.size(); i++) begin
                total++; if (sel_q[i] !== 3'(exp_sel(a, i)) || wr_c[i] < req_c[i] + lat) begin
                    bad++; $display("FAIL rnd%0d_sel[%0d]: got %0d@%0d want %0d", n, i, sel_q[i], wr_c[i], exp_sel(a, i));
                end
            end
            total++; if (tag_c.size() != 1 || wr_c.size() != 8 || tag_c[0] != wr_c[7] || done_c != tag_c[0] + 1 || busy_n != tag_c[0]) begin
                bad++; $display("FAIL rnd%0d_finish: got tag=%0d done@%0d busy=%0d", n, tag_c.size(), done_c, busy_n);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_miss_while_busy();
        test_reset_mid_fill();
        test_wrap();
        test_order();
        test_back_to_back();
        test_random();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
